store_narrow_buffer: RTL and testbench

//   Store-side counterpart of the SignExtend load/immediate path: narrows a 32-bit register value to

---
 rtl/store_narrow_buffer.sv | 158 +++++++++++++++
 tb/tb_store_narrow_buffer.sv | 229 ++++++++++++++++++++++
 2 files changed

// File: rtl/store_narrow_buffer.sv
// -----------------------------------------------------------------------------
// store_narrow_buffer
//   Store-side formatter and write buffer. Narrows a 32-bit register value to a
//   byte/halfword/word store, replicates it across the byte lanes, builds the
//   byte enables, and queues the result in a DEPTH-entry FIFO. The queue drains
//   to data memory over a valid/ready handshake.
//
// Ports
//   clk        in   single clock, rising edge
//   reset      in   synchronous, active-high reset
//   st_valid   in   store request valid
//   st_ready   out  buffer can accept (= !full)
//   st_addr    in   byte address of the store
//   st_data    in   register value (low 8/16 bits used for byte/half)
//   st_size    in   00 byte, 01 half, 10 word, 11 reserved
//   mem_valid  out  head entry valid toward memory (= !empty)
//   mem_ready  in   memory accepts the head entry
//   mem_addr   out  word-aligned address of the head entry
//   mem_wdata  out  lane-replicated write data of the head entry
//   mem_be     out  byte enables of the head entry, bit i = byte lane i
//   misalign   out  one-cycle pulse: last accepted request was misaligned/reserved
//   count      out  number of entries held
// -----------------------------------------------------------------------------
module store_narrow_buffer #(
  parameter int DEPTH = 4
) (
  input  logic                         clk,
  input  logic                         reset,
  input  logic                         st_valid,
  output logic                         st_ready,
  input  logic [31:0]                  st_addr,
  input  logic [31:0]                  st_data,
  input  logic [1:0]                   st_size,
  output logic                         mem_valid,
  input  logic                         mem_ready,
  output logic [31:0]                  mem_addr,
  output logic [31:0]                  mem_wdata,
  output logic [3:0]                   mem_be,
  output logic                         misalign,
  output logic [$clog2(DEPTH+1)-1:0]   count
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = $clog2(DEPTH + 1);

  typedef enum logic [1:0] {
    SZ_BYTE = 2'b00,
    SZ_HALF = 2'b01,
    SZ_WORD = 2'b10,
    SZ_RSVD = 2'b11
  } size_e;

  // Entry storage: only the word address is kept, low two bits are implied 0.
  logic [29:0] addr_mem  [DEPTH];
  logic [31:0] wdata_mem [DEPTH];
  logic [3:0]  be_mem    [DEPTH];

  logic [PTR_W-1:0] wr_ptr;
  logic [PTR_W-1:0] rd_ptr;
  logic [CNT_W-1:0] count_q;
  logic             misalign_q;

  logic        full;
  logic        empty;
  logic        accept;
  logic        push;
  logic        pop;
  logic        bad;
  logic [31:0] fmt_wdata;
  logic [3:0]  fmt_be;
  size_e       size;

  assign size   = size_e'(st_size);
  assign full   = (count_q == CNT_W'(DEPTH));
  assign empty  = (count_q == '0);

  // Ready depends only on occupancy, never on a same-cycle pop.
  assign st_ready  = !full;
  assign mem_valid = !empty;
  assign accept    = st_valid && st_ready;
  assign pop       = mem_valid && mem_ready;
  // Misaligned/reserved requests complete the handshake but are dropped.
  assign push      = accept && !bad;

  // Store formatting: lane replication plus byte enables.
  // NOTE: every always_comb output gets a default first so no path can infer a latch.
  always_comb begin
    fmt_wdata = st_data;
    fmt_be    = 4'b0000;
    bad       = 1'b0;
    unique case (size)
      SZ_BYTE: begin
        fmt_wdata = {4{st_data[7:0]}};
        fmt_be    = 4'b0001 << st_addr[1:0];
      end
      SZ_HALF: begin
        fmt_wdata = {2{st_data[15:0]}};
        fmt_be    = st_addr[1] ? 4'b1100 : 4'b0011;
        bad       = st_addr[0];
      end
      SZ_WORD: begin
        fmt_wdata = st_data;
        fmt_be    = 4'b1111;
        bad       = (st_addr[1:0] != 2'b00);
      end
      SZ_RSVD: begin
        bad       = 1'b1;
      end
    endcase
  end

  // Control state: pointers, occupancy and the misalign pulse.
  // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge clk) begin
    if (reset) begin
      wr_ptr     <= '0;
      rd_ptr     <= '0;
      count_q    <= '0;
      misalign_q <= 1'b0;
    end else begin
      misalign_q <= accept && bad;
      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (pop)  rd_ptr <= rd_ptr + 1'b1;
      unique case ({push, pop})
        2'b10:   count_q <= count_q + 1'b1;
        2'b01:   count_q <= count_q - 1'b1;
        default: count_q <= count_q;
      endcase
    end
  end

  // NOTE: the entry array has no reset; contents are only observable through
  // count/empty, which are reset, so clearing it would add logic for nothing.
  always_ff @(posedge clk) begin
    if (push) begin
      addr_mem[wr_ptr]  <= st_addr[31:2];
      wdata_mem[wr_ptr] <= fmt_wdata;
      be_mem[wr_ptr]    <= fmt_be;
    end
  end

  // Head entry toward memory; zeroed when empty. Stable while stalled because
  // rd_ptr and the head slot only change on a pop.
  always_comb begin
    mem_addr  = 32'h0;
    mem_wdata = 32'h0;
    mem_be    = 4'b0000;
    if (!empty) begin
      mem_addr  = {addr_mem[rd_ptr], 2'b00};
      mem_wdata = wdata_mem[rd_ptr];
      mem_be    = be_mem[rd_ptr];
    end
  end

  assign misalign = misalign_q;
  assign count    = count_q;

endmodule

// File: tb/tb_store_narrow_buffer.sv
// -----------------------------------------------------------------------------
// tb_store_narrow_buffer
//   Directed bench for store_narrow_buffer. Inputs are driven 1 ns after each
//   rising edge and outputs are sampled in that same quiet window.
// -----------------------------------------------------------------------------
module tb_store_narrow_buffer;

  logic        clk = 1'b0;
  logic        reset;
  logic        st_valid;
  logic        st_ready;
  logic [31:0] st_addr;
  logic [31:0] st_data;
  logic [1:0]  st_size;
  logic        mem_valid;
  logic        mem_ready;
  logic [31:0] mem_addr;
  logic [31:0] mem_wdata;
  logic [3:0]  mem_be;
  logic        misalign;
  logic [2:0]  count;

  int n_pass  = 0;
  int n_total = 0;

  always #5 clk = ~clk;

  store_narrow_buffer #(.DEPTH(4)) dut (
    .clk       (clk),
    .reset     (reset),
    .st_valid  (st_valid),
    .st_ready  (st_ready),
    .st_addr   (st_addr),
    .st_data   (st_data),
    .st_size   (st_size),
    .mem_valid (mem_valid),
    .mem_ready (mem_ready),
    .mem_addr  (mem_addr),
    .mem_wdata (mem_wdata),
    .mem_be    (mem_be),
    .misalign  (misalign),
    .count     (count)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic [1:0] sz, input logic [31:0] a, input logic [31:0] d);
    st_valid = 1'b1;
    st_size  = sz;
    st_addr  = a;
    st_data  = d;
  endtask

  task automatic idle();
    st_valid = 1'b0;
    st_size  = 2'b00;
    st_addr  = 32'h0;
    st_data  = 32'h0;
  endtask

  task automatic test_reset();
    reset = 1'b1; mem_ready = 1'b0; idle();
    tick(); tick();
    reset = 1'b0;
    n_total++; if (count !== 3'd0) $display("FAIL reset_count got=%0d exp=0", count); else n_pass++;
    n_total++; if (mem_valid !== 1'b0) $display("FAIL reset_mem_valid got=%b exp=0", mem_valid); else n_pass++;
    n_total++; if (misalign !== 1'b0) $display("FAIL reset_misalign got=%b exp=0", misalign); else n_pass++;
    n_total++; if ({mem_addr, mem_wdata, mem_be} !== 68'h0)
      $display("FAIL reset_mem_bus got addr=%h wdata=%h be=%b exp=0", mem_addr, mem_wdata, mem_be); else n_pass++;
    n_total++; if (st_ready !== 1'b1) $display("FAIL reset_st_ready got=%b exp=1", st_ready); else n_pass++;
  endtask

  task automatic test_byte();
    mem_ready = 1'b1;
    drive(2'b00, 32'h0000_1003, 32'hFFFF_FF5A);
    #1;
    n_total++; if (mem_valid !== 1'b0) $display("FAIL byte_no_bypass got=%b exp=0", mem_valid); else n_pass++;
    tick(); idle();
    n_total++; if (mem_valid !== 1'b1) $display("FAIL byte_valid got=%b exp=1", mem_valid); else n_pass++;
    n_total++; if (mem_addr !== 32'h0000_1000) $display("FAIL byte_addr got=%h exp=00001000", mem_addr); else n_pass++;
    n_total++; if (mem_wdata !== 32'h5A5A_5A5A) $display("FAIL byte_wdata got=%h exp=5a5a5a5a", mem_wdata); else n_pass++;
    n_total++; if (mem_be !== 4'b1000) $display("FAIL byte_be got=%b exp=1000", mem_be); else n_pass++;
    tick();
    n_total++; if (count !== 3'd0 || mem_valid !== 1'b0)
      $display("FAIL byte_drained got count=%0d valid=%b exp 0/0", count, mem_valid); else n_pass++;
  endtask

  task automatic test_half_word();
    mem_ready = 1'b0;
    drive(2'b01, 32'h0000_2002, 32'h0000_BEEF); tick();
    drive(2'b10, 32'h0000_2004, 32'h1234_5678); tick();
    drive(2'b00, 32'h0000_2009, 32'h0000_00C3); tick();
    idle();
    n_total++; if (count !== 3'd3) $display("FAIL hw_count got=%0d exp=3", count); else n_pass++;
    n_total++; if (mem_addr !== 32'h0000_2000 || mem_wdata !== 32'hBEEF_BEEF || mem_be !== 4'b1100)
      $display("FAIL hw_half got addr=%h wdata=%h be=%b exp 00002000/beefbeef/1100", mem_addr, mem_wdata, mem_be); else n_pass++;
    tick();
    n_total++; if (mem_addr !== 32'h0000_2000 || mem_wdata !== 32'hBEEF_BEEF || mem_be !== 4'b1100)
      $display("FAIL hw_stall_hold got addr=%h wdata=%h be=%b exp 00002000/beefbeef/1100", mem_addr, mem_wdata, mem_be); else n_pass++;
    mem_ready = 1'b1;
    tick();
    n_total++; if (mem_addr !== 32'h0000_2004 || mem_wdata !== 32'h1234_5678 || mem_be !== 4'b1111)
      $display("FAIL hw_word got addr=%h wdata=%h be=%b exp 00002004/12345678/1111", mem_addr, mem_wdata, mem_be); else n_pass++;
    tick();
    n_total++; if (mem_addr !== 32'h0000_2008 || mem_wdata !== 32'hC3C3_C3C3 || mem_be !== 4'b0010)
      $display("FAIL hw_byte_lane1 got addr=%h wdata=%h be=%b exp 00002008/c3c3c3c3/0010", mem_addr, mem_wdata, mem_be); else n_pass++;
    tick();
    n_total++; if (count !== 3'd0) $display("FAIL hw_drained got=%0d exp=0", count); else n_pass++;
  endtask

  task automatic test_misalign();
    logic [1:0]  sz [3] = '{2'b01, 2'b10, 2'b11};
    logic [31:0] ad [3] = '{32'h0000_3001, 32'h0000_4002, 32'h0000_5000};
    mem_ready = 1'b1;
    for (int i = 0; i < 3; i++) begin
      drive(sz[i], ad[i], 32'hFFFF_FFFF);
      #1;
      n_total++; if (st_ready !== 1'b1) $display("FAIL mis_ready_%0d got=%b exp=1", i, st_ready); else n_pass++;
      tick(); idle();
      n_total++; if (misalign !== 1'b1 || count !== 3'd0 || mem_valid !== 1'b0)
        $display("FAIL mis_pulse_%0d got mis=%b count=%0d valid=%b exp 1/0/0", i, misalign, count, mem_valid); else n_pass++;
      tick();
      n_total++; if (misalign !== 1'b0) $display("FAIL mis_one_cycle_%0d got=%b exp=0", i, misalign); else n_pass++;
    end
    // Misaligned request coinciding with a pop: only the pop changes count.
    mem_ready = 1'b0;
    drive(2'b10, 32'h0000_5000, 32'h1111_1111); tick();
    mem_ready = 1'b1;
    drive(2'b10, 32'h0000_5001, 32'h2222_2222); tick(); idle();
    n_total++; if (count !== 3'd0 || misalign !== 1'b1)
      $display("FAIL mis_with_pop got count=%0d mis=%b exp 0/1", count, misalign); else n_pass++;
    tick();
  endtask

  task automatic test_full();
    mem_ready = 1'b0;
    for (int i = 0; i < 4; i++) begin
      drive(2'b10, 32'h0000_0100 + 32'(4 * i), 32'h0000_00A0 + 32'(i));
      tick();
    end
    n_total++; if (count !== 3'd4 || st_ready !== 1'b0)
      $display("FAIL full_state got count=%0d ready=%b exp 4/0", count, st_ready); else n_pass++;
    drive(2'b10, 32'h0000_0200, 32'h0000_DEAD);
    tick();
    n_total++; if (count !== 3'd4) $display("FAIL full_no_push got=%0d exp=4", count); else n_pass++;
    // Pop while full with a request pending: no push in the same cycle.
    mem_ready = 1'b1;
    #1;
    n_total++; if (st_ready !== 1'b0) $display("FAIL full_ready_pop got=%b exp=0", st_ready); else n_pass++;
    for (int i = 0; i < 4; i++) begin
      n_total++; if (mem_addr !== 32'h0000_0100 + 32'(4 * i) || mem_wdata !== 32'h0000_00A0 + 32'(i))
        $display("FAIL full_drain_%0d got addr=%h wdata=%h exp %h/%h", i, mem_addr, mem_wdata,
                 32'h0000_0100 + 32'(4 * i), 32'h0000_00A0 + 32'(i)); else n_pass++;
      tick();
      if (i == 0) begin
        idle();
        n_total++; if (count !== 3'd3) $display("FAIL full_pop_only got=%0d exp=3", count); else n_pass++;
      end
    end
    n_total++; if (count !== 3'd0 || mem_valid !== 1'b0)
      $display("FAIL full_empty got count=%0d valid=%b exp 0/0", count, mem_valid); else n_pass++;
  endtask

  task automatic test_back_to_back();
    mem_ready = 1'b0;
    for (int i = 0; i < 2; i++) begin
      drive(2'b10, 32'h0000_0600 + 32'(4 * i), 32'hC0DE_0000 + 32'(i));
      tick();
    end
    mem_ready = 1'b1;
    for (int k = 0; k < 8; k++) begin
      drive(2'b10, 32'h0000_0600 + 32'(4 * (k + 2)), 32'hC0DE_0000 + 32'(k + 2));
      #1;
      n_total++; if (count !== 3'd2 || mem_wdata !== 32'hC0DE_0000 + 32'(k) || mem_addr !== 32'h0000_0600 + 32'(4 * k))
        $display("FAIL b2b_%0d got count=%0d addr=%h wdata=%h exp 2/%h/%h", k, count, mem_addr, mem_wdata,
                 32'h0000_0600 + 32'(4 * k), 32'hC0DE_0000 + 32'(k)); else n_pass++;
      tick();
    end
    idle();
    for (int k = 8; k < 10; k++) begin
      n_total++; if (mem_wdata !== 32'hC0DE_0000 + 32'(k))
        $display("FAIL b2b_tail_%0d got=%h exp=%h", k, mem_wdata, 32'hC0DE_0000 + 32'(k)); else n_pass++;
      tick();
    end
    n_total++; if (count !== 3'd0) $display("FAIL b2b_empty got=%0d exp=0", count); else n_pass++;
  endtask

  task automatic test_reset_mid();
    mem_ready = 1'b0;
    for (int i = 0; i < 3; i++) begin
      drive(2'b10, 32'h0000_0700 + 32'(4 * i), 32'h5555_0000 + 32'(i));
      tick();
    end
    n_total++; if (count !== 3'd3) $display("FAIL rst_pre_count got=%0d exp=3", count); else n_pass++;
    // Reset wins over a misaligned request in the same cycle.
    drive(2'b11, 32'h0000_0800, 32'h0);
    reset = 1'b1;
    tick();
    reset = 1'b0; idle();
    n_total++; if (count !== 3'd0 || mem_valid !== 1'b0 || misalign !== 1'b0)
      $display("FAIL rst_mid got count=%0d valid=%b mis=%b exp 0/0/0", count, mem_valid, misalign); else n_pass++;
    n_total++; if ({mem_addr, mem_wdata, mem_be} !== 68'h0)
      $display("FAIL rst_mid_bus got addr=%h wdata=%h be=%b exp 0", mem_addr, mem_wdata, mem_be); else n_pass++;
    mem_ready = 1'b1;
    tick();
    n_total++; if (mem_valid !== 1'b0 || count !== 3'd0)
      $display("FAIL rst_no_drain got valid=%b count=%0d exp 0/0", mem_valid, count); else n_pass++;
  endtask

  initial begin
    reset = 1'b1;
    mem_ready = 1'b0;
    idle();
    #1;
    test_reset();
    test_byte();
    test_half_word();
    test_misalign();
    test_full();
    test_back_to_back();
    test_reset_mid();
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
